fir_ctrl: RTL and testbench
===========================

# fir_ctrl

Sequencing controller in front of the FIR accelerator `top`. It owns the coefficient-write port, gates the sample stream into the accelerator, reloads coefficients atomically from a host-written shadow bank, and qualifies accelerator results so that warm-up outputs are never reported. It sits between the host/sensor interfaces and `top`.

## Interface
- `DATA_WIDTH`, default 16: sample, coefficient and result width, in signed fixed point, same format as `top`.
- `NUM_REGS`, default 8: FIR taps (must match `top`); the coefficient address is `$clog2(NUM_REGS)` bits (3 at default).
- `FIR_LAT`, default 1: cycles from an accepted sample (`accelerateEn`=1) to its `resultIsValid` pulse from `top`.
- `clk`  in  1  clock; everything is synchronous to the rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `hostWrEn`  in  1  writes `hostData` into shadow slot `hostAddr`.
- `hostAddr`  in  3  shadow slot index.
- `hostData`  in  DATA_WIDTH  coefficient value.
- `hostCommit`  in  1  one-cycle pulse requesting a reload of the shadow bank into `top`.
- `hostBusy`  out  1  high while in LOAD; host writes are ignored while it is high.
- `sampleValid`  in  1  sensor sample present.
- `sampleIn`  in  DATA_WIDTH  sensor sample.
- `sampleReady`  out  1  the sample is accepted on a cycle where `sampleValid && sampleReady`.
- `clrC`, `coeffWriteEn`, `coeffAddress`[3], `coeffIn`[DATA_WIDTH], `accelerateEn`, `rawSensorVal`[DATA_WIDTH]  out  drive the matching ports of `top`.
- `macResult`[DATA_WIDTH], `resultIsValid`  in  from `top`.
- `outData`  out  DATA_WIDTH  qualified filter result.
- `outValid`  out  1  one-cycle strobe marking `outData` valid.

## Operation
- The shadow bank holds NUM_REGS registers and resets to 0. A write lands when `hostWrEn && !hostBusy`.
- The FSM has two states: RUN (the reset state) and LOAD.
- RUN:
  - `sampleReady`=1.
  - `accelerateEn = sampleValid`.
  - `rawSensorVal = sampleIn`, combinational pass-through.
- RUN to LOAD occurs on `hostCommit`, or on a latched pending commit. On a commit that coincides with `sampleValid`, the sample is still accepted that cycle and LOAD starts on the next cycle.
- LOAD:
  - `sampleReady`=0 and `accelerateEn`=0.
  - `clrC`=1 in the first LOAD cycle only.
  - For NUM_REGS cycles, `coeffWriteEn`=1 with `coeffAddress` stepping 0 to NUM_REGS-1 and `coeffIn` = shadow[addr].
  - After the last address, the FSM returns to RUN.
- A `hostCommit` arriving during LOAD sets a pending flag. That causes exactly one further LOAD immediately after the current one; multiple commits collapse to one.
- Warm-up counter: set to NUM_REGS on reset and on LOAD exit, and decremented on each accepted sample while it is non-zero. Each accept pushes a tag bit (counter≠0) into a FIR_LAT-deep shift register.
- Result qualification: on `resultIsValid`, if the aligned tag is 0, register `outData`=`macResult` and pulse `outValid`. Otherwise drop the result.
- `resultIsValid` arriving in LOAD is dropped, and the tag pipe is flushed on LOAD entry.

## Timing
- Reset values:
  - State RUN; `sampleReady`=1.
  - `hostBusy`, `clrC`, `coeffWriteEn`, `accelerateEn` are 0.
  - `coeffAddress`, `coeffIn`, `outData` are 0; `outValid`=0.
  - Warm counter = NUM_REGS; tags, pending flag and shadow bank cleared.
- Commit at cycle T in RUN: `hostBusy`/`coeffWriteEn` are high for cycles T+1..T+NUM_REGS, and `sampleReady` returns to 1 at T+NUM_REGS+1.
- Result path: `outValid` rises 1 cycle after `resultIsValid`, i.e. FIR_LAT+1 cycles after the accept. Throughput is one sample per cycle.
- A simultaneous `hostWrEn` and `hostCommit` in RUN lands the write first; the reload uses the new value.
- Reset asserted mid-LOAD aborts immediately to the reset values. `top` is left partially loaded, and the host must re-commit.

## Configuration
- `FIR_CTRL_WARMUP_EN`:
  - Defined: warm-up counter and tag pipe are present as described.
  - Undefined: counter and tags are removed, and every `resultIsValid` outside LOAD yields `outValid`.

## Test plan
- Reset, write shadow slots 0..7 = 0.2, commit → `coeffWriteEn` high 8 cycles, addresses 0..7, `coeffIn`=r2f(0.2) each, `clrC` only on first, `hostBusy` low after.
- After the load, stream 16 samples all 1.0 → first 8 results suppressed, results 9..16 give `outValid` with `outData`=1.6, FIR_LAT+1 latency.
- Commit during LOAD plus two extra commits → exactly two back-to-back 8-cycle loads, `sampleReady` low for 16 cycles.
- `hostWrEn` slot 3 = 0.5 during LOAD → ignored; a subsequent load writes the previous value to address 3.
- Assert `rstN` low at LOAD cycle 4 → all outputs at reset values next edge, `coeffWriteEn`=0, warm counter back to 8.
- Build without `FIR_CTRL_WARMUP_EN`, stream 3 samples after reset → 3 `outValid` pulses.

Source files
------------

// File: rtl/fir_ctrl.sv
// fir_ctrl: sequencing controller in front of the FIR accelerator `top`.
//
// Holds a host-written shadow coefficient bank and reloads it into `top` in one
// atomic burst (LOAD). Gates the sample stream while loading and qualifies
// accelerator results so that warm-up outputs are never reported.
//
// Ports:
//   clk, rstN                       clock, asynchronous active-low reset
//   hostWrEn/hostAddr/hostData      shadow bank write (ignored while hostBusy)
//   hostCommit                      request a reload of the shadow bank into `top`
//   hostBusy                        high while loading
//   sampleValid/sampleIn/sampleReady  sensor sample handshake
//   clrC, coeffWriteEn, coeffAddress, coeffIn, accelerateEn, rawSensorVal  to `top`
//   macResult, resultIsValid        from `top`
//   outData, outValid               qualified filter result and its strobe
//
// Build option: define FIR_CTRL_WARMUP_EN to include the warm-up counter and tag
// pipe that suppress the first NUM_REGS results after reset or a reload.
// Without it, every result arriving outside LOAD is reported.

module fir_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned FIR_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        hostWrEn,
  input  logic [$clog2(NUM_REGS)-1:0] hostAddr,
  input  logic [DATA_WIDTH-1:0]       hostData,
  input  logic                        hostCommit,
  output logic                        hostBusy,
  input  logic                        sampleValid,
  input  logic [DATA_WIDTH-1:0]       sampleIn,
  output logic                        sampleReady,
  output logic                        clrC,
  output logic                        coeffWriteEn,
  output logic [$clog2(NUM_REGS)-1:0] coeffAddress,
  output logic [DATA_WIDTH-1:0]       coeffIn,
  output logic                        accelerateEn,
  output logic [DATA_WIDTH-1:0]       rawSensorVal,
  input  logic [DATA_WIDTH-1:0]       macResult,
  input  logic                        resultIsValid,
  output logic [DATA_WIDTH-1:0]       outData,
  output logic                        outValid
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  if (FIR_LAT < 1) begin : g_bad_lat
    $error("fir_ctrl: FIR_LAT must be at least 1");
  end

  typedef enum logic {StRun, StLoad} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
  logic                  pend_q;
  logic                  clr_q;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] coeff_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;

  logic                  busy;
  logic                  wr_ok;
  logic                  accept;
  logic                  last_addr;
  logic [AW-1:0]         addr_nxt;
  logic [DATA_WIDTH-1:0] first_coeff;
  logic                  suppress;
  logic                  report;

  assign busy      = (state_q == StLoad);
  assign wr_ok     = hostWrEn && !busy;
  assign accept    = sampleValid && !busy;
  assign last_addr = (addr_q == AW'(NUM_REGS - 1));
  assign addr_nxt  = addr_q + 1'b1;

  // A write landing in the same cycle as a commit must reach the reload, so
  // bypass it for slot 0; later slots are read after the write has landed.
  assign first_coeff = (wr_ok && hostAddr == '0) ? hostData : shadow_q[0];

  // Shadow bank
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (wr_ok) begin
      shadow_q[hostAddr] <= hostData;
    end
  end

  // Load sequencer
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= StRun;
      pend_q  <= 1'b0;
      clr_q   <= 1'b0;
      addr_q  <= '0;
      coeff_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hostCommit) begin
            state_q <= StLoad;
            clr_q   <= 1'b1;
            addr_q  <= '0;
            coeff_q <= first_coeff;
          end
        end
        StLoad: begin
          clr_q <= 1'b0;
          if (hostCommit) begin
            pend_q <= 1'b1;
          end
          if (last_addr) begin
            if (pend_q || hostCommit) begin
              // Back-to-back reload; any number of commits collapse into this one.
              pend_q  <= 1'b0;
              clr_q   <= 1'b1;
              addr_q  <= '0;
              coeff_q <= shadow_q[0];
            end else begin
              state_q <= StRun;
              addr_q  <= '0;
              coeff_q <= '0;
            end
          end else begin
            addr_q  <= addr_nxt;
            coeff_q <= shadow_q[addr_nxt];
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

`ifdef FIR_CTRL_WARMUP_EN
  localparam int unsigned WW = $clog2(NUM_REGS + 1);

  logic [WW-1:0]      warm_q;
  logic [FIR_LAT-1:0] tag_q;
  logic               tag_in;

  // Idle slots push a 1 so that nothing unaccounted for is ever reported.
  assign tag_in   = accept ? (warm_q != '0) : 1'b1;
  assign suppress = tag_q[FIR_LAT-1];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      warm_q <= WW'(NUM_REGS);
      tag_q  <= '0;
    end else if (busy) begin
      // Held at full count throughout LOAD, so it is NUM_REGS on exit.
      warm_q <= WW'(NUM_REGS);
      tag_q  <= '0;
    end else begin
      if (accept && warm_q != '0) begin
        warm_q <= warm_q - 1'b1;
      end
      tag_q <= (tag_q << 1) | FIR_LAT'(tag_in);
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign report = resultIsValid && !busy && !suppress;

  // Result qualification
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= report;
      if (report) begin
        out_data_q <= macResult;
      end
    end
  end

  assign hostBusy     = busy;
  assign sampleReady  = !busy;
  assign accelerateEn = accept;
  assign rawSensorVal = sampleIn;
  assign clrC         = clr_q;
  assign coeffWriteEn = busy;
  assign coeffAddress = addr_q;
  assign coeffIn      = coeff_q;
  assign outData      = out_data_q;
  assign outValid     = out_valid_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: directed self-checking bench for fir_ctrl.
// A small behavioural stand-in for `top` (Q8.8 coefficients and samples,
// FIR_LAT = 1) supplies macResult/resultIsValid. Expected values are
// hand-derived: 0.2 -> 51, 1.0 -> 256, 8 taps of 0.2 x 1.0 -> 408.

module tb_fir_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 8;

  logic          clk = 1'b0;
  logic          rstN;
  logic          hostWrEn;
  logic [2:0]    hostAddr;
  logic [DW-1:0] hostData;
  logic          hostCommit;
  logic          hostBusy;
  logic          sampleValid;
  logic [DW-1:0] sampleIn;
  logic          sampleReady;
  logic          clrC;
  logic          coeffWriteEn;
  logic [2:0]    coeffAddress;
  logic [DW-1:0] coeffIn;
  logic          accelerateEn;
  logic [DW-1:0] rawSensorVal;
  logic [DW-1:0] macResult = '0;
  logic          resultIsValid = 1'b0;
  logic [DW-1:0] outData;
  logic          outValid;

  int total = 0;
  int bad   = 0;

  fir_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(NR), .FIR_LAT(1)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .hostWrEn     (hostWrEn),
    .hostAddr     (hostAddr),
    .hostData     (hostData),
    .hostCommit   (hostCommit),
    .hostBusy     (hostBusy),
    .sampleValid  (sampleValid),
    .sampleIn     (sampleIn),
    .sampleReady  (sampleReady),
    .clrC         (clrC),
    .coeffWriteEn (coeffWriteEn),
    .coeffAddress (coeffAddress),
    .coeffIn      (coeffIn),
    .accelerateEn (accelerateEn),
    .rawSensorVal (rawSensorVal),
    .macResult    (macResult),
    .resultIsValid(resultIsValid),
    .outData      (outData),
    .outValid     (outValid)
  );

  always #5 clk = ~clk;

  // Stand-in for the accelerator: 8-tap FIR, Q8.8, result one cycle after accept.
  logic signed [DW-1:0] m_coef [NR];
  logic signed [DW-1:0] m_dl   [NR];

  function automatic logic [DW-1:0] fir_sum(input logic signed [DW-1:0] x);
    int acc;
    acc = (int'(m_coef[0]) * int'(x)) >>> 8;
    for (int i = 1; i < NR; i++) begin
      acc += (int'(m_coef[i]) * int'(m_dl[i-1])) >>> 8;
    end
    return acc[DW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (coeffWriteEn) m_coef[coeffAddress] <= coeffIn;
    if (clrC) begin
      for (int i = 0; i < NR; i++) m_dl[i] <= '0;
    end else if (accelerateEn) begin
      for (int i = 1; i < NR; i++) m_dl[i] <= m_dl[i-1];
      m_dl[0] <= rawSensorVal;
    end
    resultIsValid <= accelerateEn;
    if (accelerateEn) macResult <= fir_sum(rawSensorVal);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic host_write(input logic [2:0] a, input logic [DW-1:0] d);
    hostWrEn = 1'b1; hostAddr = a; hostData = d;
    @(negedge clk);
    hostWrEn = 1'b0;
  endtask

  // Leaves the bench at the negedge of the first LOAD cycle.
  task automatic commit();
    hostCommit = 1'b1;
    @(negedge clk);
    hostCommit = 1'b0;
  endtask

  // Checks n LOAD cycles; disturb adds extra commits, an ignored host write and
  // a pending sample during the load.
  task automatic load_check(input int n, input logic [DW-1:0] exp_c,
                            input logic [DW-1:0] exp3, input bit disturb);
    for (int k = 0; k < n; k++) begin
      check("busy", hostBusy, 1);
      check("coeff_we", coeffWriteEn, 1);
      check("coeff_addr", coeffAddress, k % NR);
      check("coeff_in", coeffIn, (k % NR == 3) ? exp3 : exp_c);
      check("clr_c", clrC, (k % NR == 0) ? 1 : 0);
      check("ready_in_load", sampleReady, 0);
      if (disturb) begin
        check("acc_en_in_load", accelerateEn, 0);
        check("out_valid_in_load", outValid, 0);
        hostCommit = (k == 2 || k == 5 || k == 7);
        hostWrEn   = (k == 3);
        hostAddr   = 3'd3;
        hostData   = 16'd128;
      end
      @(negedge clk);
    end
    hostCommit  = 1'b0;
    hostWrEn    = 1'b0;
    sampleValid = 1'b0;
    check("busy_after", hostBusy, 0);
    check("we_after", coeffWriteEn, 0);
    check("ready_after", sampleReady, 1);
  endtask

  // 16 samples of 1.0; outValid for sample j is visible two negedges later.
  task automatic stream();
    int j;
    bit exp_v;
    for (int i = 0; i < 18; i++) begin
      j = i - 2;
`ifdef FIR_CTRL_WARMUP_EN
      exp_v = (j >= 8) && (j < 16);
`else
      exp_v = (j >= 0) && (j < 16);
`endif
      check("out_valid", outValid, exp_v);
      if (exp_v) check("out_data", outData, 51 * ((j + 1 < 8) ? j + 1 : 8));
      sampleValid = (i < 16);
      sampleIn    = 16'd256;
      #1;
      check("acc_en", accelerateEn, (i < 16) ? 1 : 0);
      check("raw_val", rawSensorVal, 256);
      @(negedge clk);
    end
    sampleValid = 1'b0;
  endtask

  task automatic write_all(input logic [DW-1:0] d);
    for (int a = 0; a < NR; a++) host_write(a[2:0], d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstN = 1'b0; hostWrEn = 1'b0; hostAddr = '0; hostData = '0; hostCommit = 1'b0;
    sampleValid = 1'b0; sampleIn = '0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    check("rst_ready", sampleReady, 1);
    check("rst_busy", hostBusy, 0);
    check("rst_clr", clrC, 0);
    check("rst_we", coeffWriteEn, 0);
    check("rst_acc", accelerateEn, 0);
    check("rst_addr", coeffAddress, 0);
    check("rst_cin", coeffIn, 0);
    check("rst_odata", outData, 0);
    check("rst_ovalid", outValid, 0);

    // Initial load of 0.2 into every tap, then warm-up stream
    write_all(16'd51);
    commit();
    load_check(NR, 16'd51, 16'd51, 1'b0);
    stream();

    // Commit with a concurrent sample, plus commits and a write during LOAD
    sampleValid = 1'b1;
    sampleIn    = 16'd256;
    commit();
    load_check(2 * NR, 16'd51, 16'd51, 1'b1);

    // Write and commit in the same RUN cycle: reload sees the new value
    hostWrEn = 1'b1; hostAddr = 3'd3; hostData = 16'd128; hostCommit = 1'b1;
    @(negedge clk);
    hostWrEn = 1'b0; hostCommit = 1'b0;
    load_check(NR, 16'd51, 16'd128, 1'b0);

    // Reset in LOAD cycle 4 aborts straight to reset values
    commit();
    repeat (3) @(negedge clk);
    check("pre_rst_addr", coeffAddress, 3);
    rstN = 1'b0;
    #1;
    check("ab_busy", hostBusy, 0);
    check("ab_we", coeffWriteEn, 0);
    check("ab_clr", clrC, 0);
    check("ab_addr", coeffAddress, 0);
    check("ab_cin", coeffIn, 0);
    check("ab_ready", sampleReady, 1);
    check("ab_ovalid", outValid, 0);
    check("ab_odata", outData, 0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // Shadow bank was cleared by the reset
    commit();
    load_check(NR, 16'd0, 16'd0, 1'b0);

    // Warm-up counter is back at full count after reset and reload
    write_all(16'd51);
    commit();
    load_check(NR, 16'd51, 16'd51, 1'b0);
    stream();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
